// File: rtl/vec_issue_control_if.sv
// Issue-control handshake bundle: instruction offer, memory ack and registered control outputs.
// slave = issue controller side, master = instruction source / datapath side.
interface vec_issue_control_if #(
  parameter int IDXW = 3
);
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [6:0]      opcode_i;
  logic            mem_ack_i;
  logic [1:0]      ALUOp_o;
  logic            ALUSrc_o;
  logic            RegWrite_o;
  logic            MemRead_o;
  logic            MemWrite_o;
  logic            MemtoReg_o;
  logic            immSelect_o;
  logic            vec_o;
  logic [IDXW-1:0] elem_idx_o;
  logic            ctrl_valid_o;
  logic            done_o;
  logic            timeout_o;

  modport master (
    output instr_valid_i, opcode_i, mem_ack_i,
    input  instr_ready_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o,
           MemtoReg_o, immSelect_o, vec_o, elem_idx_o, ctrl_valid_o, done_o, timeout_o
  );

  modport slave (
    input  instr_valid_i, opcode_i, mem_ack_i,
    output instr_ready_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o,
           MemtoReg_o, immSelect_o, vec_o, elem_idx_o, ctrl_valid_o, done_o, timeout_o
  );
endinterface

// File: rtl/vec_issue_control.sv
// Vector-aware issue control: decodes an opcode into registered datapath controls; CTRL_ILLEGAL_TRAP_EN adds illegal_o.
// Latency: 1 cycle accept-to-ctrl_valid_o; ALU 1 beat, VEC NUM_ELEMS/LANES beats, MEM until ack or MEM_TIMEOUT.
// Backpressure: instr_ready_o high only in IDLE or a retiring (done_o) cycle; offers at other times are ignored.
module vec_issue_control #(
  parameter int NUM_ELEMS   = 8,
  parameter int LANES       = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic illegal_o,
`endif
  vec_issue_control_if.slave bus
);
  localparam int IDXW  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int BEATS = NUM_ELEMS / LANES;

  typedef enum logic [1:0] {IDLE, ALU, MEM, VEC} state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       imm_sel;
  } ctrl_t;

  state_t          state_q, state_d, dec_state;
  ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            vec_q, vec_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            tmo_q, tmo_d;
  logic            rdy_q, rdy_d;
  logic            accept;
  logic            tmo_hit;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            dec_ill;
  logic            ill_q;
`endif

  assign accept  = bus.instr_valid_i & rdy_q;
  // cnt_q holds MEM cycles already shown; timeout becomes visible on cycle MEM_TIMEOUT
  assign tmo_hit = (int'(cnt_q) + 2 == MEM_TIMEOUT);

  always_comb begin
    dec_ctrl  = '0;
    dec_state = ALU;
`ifdef CTRL_ILLEGAL_TRAP_EN
    dec_ill   = 1'b0;
`endif
    case (bus.opcode_i)
      7'b0010011: dec_ctrl = ctrl_t'(8'b11_1_1_0_0_0_0);
      7'b0110011: dec_ctrl = ctrl_t'(8'b10_0_1_0_0_0_0);
      7'b1100011: dec_ctrl = ctrl_t'(8'b01_1_0_0_0_0_0);
      7'b0000011: begin dec_ctrl = ctrl_t'(8'b00_1_1_1_0_1_0); dec_state = MEM; end
      7'b0100011: begin dec_ctrl = ctrl_t'(8'b00_1_0_0_1_0_1); dec_state = MEM; end
      7'b1010111: begin dec_ctrl = ctrl_t'(8'b00_0_1_0_0_0_0); dec_state = VEC; end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        dec_ill  = 1'b1;
`else
        dec_ctrl = ctrl_t'(8'b11_1_0_0_0_0_0);
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    rdy_d   = 1'b0;
    if (accept) begin
      state_d = dec_state;
      ctrl_d  = dec_ctrl;
      idx_d   = '0;
      cnt_d   = '0;
      vec_d   = (dec_state == VEC);
      valid_d = 1'b1;
      case (dec_state)
        ALU:     done_d = 1'b1;
        VEC:     done_d = (BEATS == 1);
        MEM: begin
          done_d = (MEM_TIMEOUT == 1);
          tmo_d  = (MEM_TIMEOUT == 1);
        end
        default: done_d = 1'b0;
      endcase
      rdy_d = done_d;
    end else if (state_q == IDLE || done_q) begin
      state_d = IDLE;
      ctrl_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      vec_d   = 1'b0;
      valid_d = 1'b0;
      rdy_d   = 1'b1;
    end else if (state_q == MEM) begin
      // an ack sampled on the same edge as the timeout retires normally
      cnt_d  = cnt_q + 8'd1;
      done_d = bus.mem_ack_i | tmo_hit;
      tmo_d  = tmo_hit & ~bus.mem_ack_i;
      rdy_d  = done_d;
    end else if (state_q == VEC) begin
      idx_d  = idx_q + IDXW'(LANES);
      done_d = (int'(idx_q) + 2 * LANES >= NUM_ELEMS);
      rdy_d  = done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // illegal opcodes always retire in a single ALU cycle, so the flag lasts one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ill_q <= 1'b0;
    else         ill_q <= accept & dec_ill;
  end
  assign illegal_o = ill_q;
`endif

  assign bus.instr_ready_o = rdy_q;
  assign bus.ALUOp_o       = ctrl_q.alu_op;
  assign bus.ALUSrc_o      = ctrl_q.alu_src;
  assign bus.RegWrite_o    = ctrl_q.reg_write;
  assign bus.MemRead_o     = ctrl_q.mem_read;
  assign bus.MemWrite_o    = ctrl_q.mem_write;
  assign bus.MemtoReg_o    = ctrl_q.mem_to_reg;
  assign bus.immSelect_o   = ctrl_q.imm_sel;
  assign bus.vec_o         = vec_q;
  assign bus.elem_idx_o    = idx_q;
  assign bus.ctrl_valid_o  = valid_q;
  assign bus.done_o        = done_q;
  assign bus.timeout_o     = tmo_q;
endmodule

// File: tb/tb_vec_issue_control.sv
// Directed bench for vec_issue_control (NUM_ELEMS=8, LANES=2, MEM_TIMEOUT=15); CTRL_ILLEGAL_TRAP_EN selects the trap build.
module tb_vec_issue_control;
  localparam int NE   = 8;
  localparam int LN   = 2;
  localparam int MT   = 15;
  localparam int IDXW = 3;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_VEC  = 7'b1010111;
  localparam logic [6:0] OP_UNK  = 7'b1111111;

  // {ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, immSelect}
  localparam logic [7:0] C_ADDI = 8'b11_1_1_0_0_0_0;
  localparam logic [7:0] C_ADD  = 8'b10_0_1_0_0_0_0;
  localparam logic [7:0] C_BR   = 8'b01_1_0_0_0_0_0;
  localparam logic [7:0] C_LD   = 8'b00_1_1_1_0_1_0;
  localparam logic [7:0] C_ST   = 8'b00_1_0_0_1_0_1;
  localparam logic [7:0] C_VEC  = 8'b00_0_1_0_0_0_0;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [7:0] C_UNK  = 8'b00_0_0_0_0_0_0;
`else
  localparam logic [7:0] C_UNK  = 8'b11_1_0_0_0_0_0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vec_issue_control_if #(.IDXW(IDXW)) bus ();

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  vec_issue_control #(
    .NUM_ELEMS  (NE),
    .LANES      (LN),
    .MEM_TIMEOUT(MT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_o(illegal),
`endif
    .bus      (bus)
  );

  // {ctrl_valid, done, timeout, ready, vec, elem_idx[2:0], ctrl[7:0]}
  logic [15:0] obs;
  assign obs = {bus.ctrl_valid_o, bus.done_o, bus.timeout_o, bus.instr_ready_o, bus.vec_o,
                bus.elem_idx_o, bus.ALUOp_o, bus.ALUSrc_o, bus.RegWrite_o, bus.MemRead_o,
                bus.MemWrite_o, bus.MemtoReg_o, bus.immSelect_o};

  function automatic logic [15:0] exp_w(input logic v, input logic d, input logic t,
                                        input logic r, input logic vc,
                                        input logic [2:0] idx, input logic [7:0] c);
    return {v, d, t, r, vc, idx, c};
  endfunction

  localparam logic [15:0] W_IDLE = 16'h1000;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op);
    bus.opcode_i      = op;
    bus.instr_valid_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.instr_valid_i = 1'b0;
    bus.opcode_i      = '0;
    bus.mem_ack_i     = 1'b0;
    #3;
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, 16'h0000); end
    bus.instr_valid_i = 1'b1;
    bus.opcode_i      = OP_ADD;
    step();
    step();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_ignores_valid: got %h want %h", obs, 16'h0000); end
    bus.instr_valid_i = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL reset_release_ready: got %h want %h", obs, W_IDLE); end
  endtask

  task automatic test_alu;
    logic [6:0] ops [5];
    logic [7:0] cs  [5];
    ops = '{OP_ADD, OP_ADDI, OP_BR, OP_UNK, OP_ADD};
    cs  = '{C_ADD, C_ADDI, C_BR, C_UNK, C_ADD};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i]);
      checks++;
      if (obs !== exp_w(1, 1, 0, 1, 0, 0, cs[i])) begin
        errors++; $display("FAIL alu_op%b: got %h want %h", ops[i], obs, exp_w(1, 1, 0, 1, 0, 0, cs[i]));
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== (ops[i] == OP_UNK)) begin
        errors++; $display("FAIL illegal_op%b: got %b want %b", ops[i], illegal, ops[i] == OP_UNK);
      end
`endif
      step();
      checks++;
      if (obs !== W_IDLE) begin errors++; $display("FAIL alu_return_idle%0d: got %h want %h", i, obs, W_IDLE); end
    end
  endtask

  task automatic test_mem_ack;
    issue(OP_LD);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (obs !== exp_w(1, k == 4, 0, k == 4, 0, 0, C_LD)) begin
        errors++; $display("FAIL mem_ack_cyc%0d: got %h want %h", k, obs, exp_w(1, k == 4, 0, k == 4, 0, 0, C_LD));
      end
      bus.mem_ack_i = (k == 3);
      if (k < 4) step();
    end
    bus.mem_ack_i = 1'b0;
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL mem_ack_idle: got %h want %h", obs, W_IDLE); end
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL ack_outside_mem: got %h want %h", obs, W_IDLE); end
  endtask

  task automatic test_mem_timeout;
    issue(OP_ST);
    for (int k = 1; k <= MT; k++) begin
      checks++;
      if (obs !== exp_w(1, k == MT, k == MT, k == MT, 0, 0, C_ST)) begin
        errors++; $display("FAIL timeout_cyc%0d: got %h want %h", k, obs, exp_w(1, k == MT, k == MT, k == MT, 0, 0, C_ST));
      end
      if (k < MT) step();
    end
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL timeout_idle: got %h want %h", obs, W_IDLE); end
  endtask

  task automatic test_ack_beats_timeout;
    issue(OP_ST);
    for (int k = 1; k <= MT; k++) begin
      checks++;
      if (obs !== exp_w(1, k == MT, 0, k == MT, 0, 0, C_ST)) begin
        errors++; $display("FAIL ack_wins_cyc%0d: got %h want %h", k, obs, exp_w(1, k == MT, 0, k == MT, 0, 0, C_ST));
      end
      bus.mem_ack_i = (k == MT - 1);
      if (k < MT) step();
    end
    bus.mem_ack_i = 1'b0;
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL ack_wins_idle: got %h want %h", obs, W_IDLE); end
  endtask

  task automatic test_back_to_back;
    bus.opcode_i      = OP_VEC;
    bus.instr_valid_i = 1'b1;
    step();
    // valid held high through busy beats; only the last beat may accept it
    bus.opcode_i = OP_ADD;
    for (int k = 1; k <= NE / LN; k++) begin
      checks++;
      if (obs !== exp_w(1, k == 4, 0, k == 4, 1, 3'((k - 1) * LN), C_VEC)) begin
        errors++; $display("FAIL vec_beat%0d: got %h want %h", k, obs, exp_w(1, k == 4, 0, k == 4, 1, 3'((k - 1) * LN), C_VEC));
      end
      if (k < NE / LN) step();
    end
    step();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (obs !== exp_w(1, 1, 0, 1, 0, 0, C_ADD)) begin
      errors++; $display("FAIL b2b_no_bubble: got %h want %h", obs, exp_w(1, 1, 0, 1, 0, 0, C_ADD));
    end
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL b2b_idle: got %h want %h", obs, W_IDLE); end
  endtask

  task automatic test_reset_mid_vec;
    issue(OP_VEC);
    step();
    checks++;
    if (obs !== exp_w(1, 0, 0, 0, 1, 3'd2, C_VEC)) begin
      errors++; $display("FAIL midvec_beat2: got %h want %h", obs, exp_w(1, 0, 0, 0, 1, 3'd2, C_VEC));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL midvec_async_clear: got %h want %h", obs, 16'h0000); end
    step();
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL midvec_in_reset: got %h want %h", obs, 16'h0000); end
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== W_IDLE) begin errors++; $display("FAIL midvec_no_done: got %h want %h", obs, W_IDLE); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_ack();
    test_mem_timeout();
    test_ack_beats_timeout();
    test_back_to_back();
    test_reset_mid_vec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vec_issue_control.md
VEC_ISSUE_CONTROL -- requirements
Module: vec_issue_control

Interface
REQ-001 Parameter NUM_ELEMS, default 8, elements per vector instruction; legal range 1..256.
REQ-002 Parameter LANES, default 2, elements per vector beat; NUM_ELEMS SHALL be a multiple of LANES.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum MEM-state cycles without mem_ack_i; legal range 1..255.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 instr_valid_i  in  1  opcode_i is offered.
REQ-007 instr_ready_o  out  1  block accepts an opcode this cycle.
REQ-008 opcode_i  in  7  instruction opcode field.
REQ-009 mem_ack_i  in  1  data-memory access complete.
REQ-010 ALUOp_o  out  2  ALU operation class.
REQ-011 ALUSrc_o  out  1  1 = immediate operand B.
REQ-012 RegWrite_o  out  1  register-file write enable.
REQ-013 MemRead_o  out  1  data-memory read enable.
REQ-014 MemWrite_o  out  1  data-memory write enable.
REQ-015 MemtoReg_o  out  1  1 = writeback from memory.
REQ-016 immSelect_o  out  1  1 = S-type immediate.
REQ-017 vec_o  out  1  current step is a vector beat.
REQ-018 elem_idx_o  out  max(1,$clog2(NUM_ELEMS))  first element index of current beat.
REQ-019 ctrl_valid_o  out  1  control outputs valid this cycle.
REQ-020 done_o  out  1  one-cycle pulse on instruction retire.
REQ-021 timeout_o  out  1  one-cycle pulse on memory timeout.

Function
REQ-022 States IDLE, ALU, MEM, VEC; all outputs SHALL be registered; instruction accepted on instr_valid_i & instr_ready_o, opcode latched.
REQ-023 instr_ready_o SHALL be 1 in IDLE and in any cycle with done_o=1, else 0; acceptance in a done_o cycle enters the new instruction's state next cycle with no IDLE bubble.
REQ-024 Decode (ALUOp,ALUSrc,RegWrite,MemRead,MemWrite,MemtoReg,immSelect): 0010011 -> 11,1,1,0,0,0,0; 0110011 -> 10,0,1,0,0,0,0; 1100011 -> 01,1,0,0,0,0,0.
REQ-025 Decode continued: 0000011 -> 00,1,1,1,0,1,0; 0100011 -> 00,1,0,0,1,0,1; 1010111 -> 00,0,1,0,0,0,0 with vec_o=1; any other -> 11,1,0,0,0,0,0.
REQ-026 Whenever ctrl_valid_o=0, all decode outputs, vec_o and elem_idx_o SHALL be 0.
REQ-027 ALU state (opcodes 0010011, 0110011, 1100011, unknown): exactly one cycle with ctrl_valid_o=1 and done_o=1; latency accept-edge to ctrl_valid_o is 1 cycle.
REQ-028 MEM state (0000011, 0100011): ctrl_valid_o and decode outputs held until mem_ack_i=1; done_o=1 in the ack cycle.
REQ-029 MEM wait counter starts at 0 on entry; after MEM_TIMEOUT cycles without ack, timeout_o=1 and done_o=1 in that cycle, instruction retired.
REQ-030 mem_ack_i in the same cycle as timeout SHALL win: done_o=1, timeout_o=0; mem_ack_i outside MEM SHALL be ignored.
REQ-031 VEC state: NUM_ELEMS/LANES consecutive beats with ctrl_valid_o=1, elem_idx_o = 0, LANES, 2*LANES, ...; done_o=1 only on the last beat.
REQ-032 NUM_ELEMS=LANES SHALL give a single-beat vector instruction identical in timing to REQ-027.
REQ-033 instr_valid_i while instr_ready_o=0 SHALL have no effect.

Reset
REQ-034 rst_ni=0 SHALL immediately force state IDLE, counters 0, every output 0 except instr_ready_o, which SHALL be 1 from the first clock edge after deassertion.
REQ-035 Reset mid-instruction (MEM or VEC) SHALL abort it with no done_o or timeout_o pulse.

Configuration
REQ-036 Macro CTRL_ILLEGAL_TRAP_EN defined: extra port illegal_o (out, 1); an unknown opcode yields one ALU-state cycle with illegal_o=1, done_o=1, and all decode outputs 0.
REQ-037 Macro undefined: no illegal_o port; unknown opcodes decode per REQ-025 default.

Verification
REQ-038 Reset, then 0110011 accepted -> next cycle ctrl_valid_o=1, ALUOp_o=10, RegWrite_o=1, done_o=1.
REQ-039 0000011, mem_ack_i after 3 cycles -> MemRead_o=MemtoReg_o=1 held 4 cycles, done_o on 4th, timeout_o=0.
REQ-040 0100011, no ack, MEM_TIMEOUT=15 -> timeout_o=done_o=1 on cycle 15; ack on cycle 15 -> timeout_o=0.
REQ-041 1010111, NUM_ELEMS=8, LANES=2 -> 4 beats, elem_idx_o 0,2,4,6, done_o on beat 4; next opcode accepted on beat 4 runs with no bubble.
REQ-042 rst_ni low during VEC beat 2 -> all outputs 0 at once, no done_o; 1111111 with CTRL_ILLEGAL_TRAP_EN -> illegal_o=1, RegWrite_o=0.
